// File: rtl/rr_arbiter_8_if.sv
// rtl/rr_arbiter_8_if.sv - request/grant bundle between 8 requesters and rr_arbiter_8
interface rr_arbiter_8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  modport master (output en, output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input en, input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with request/hold/release tenure
// Optional tenure limit of HOLD_MAX cycles is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("rr_arbiter_8: HOLD_MAX out of range 1..255");
    end
  endgenerate

  logic [0:0] state;
  logic [2:0] ptr;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic       valid_q;

  logic       sel_found;
  logic [2:0] sel_idx;
  logic [2:0] cand;

  // Walk downward so the last hit is the one nearest ptr (rotating priority).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt     <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && sel_found) begin
            gnt_q   <= 8'b1 << sel_idx;
            idx_q   <= sel_idx;
            valid_q <= 1'b1;
            state   <= GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            cnt     <= 8'd0;
`endif
          end
        end
        GRANT: begin
          // Release and timeout revoke share the same exit path.
          if (!bus.req[idx_q]
`ifdef RR_ARB_TIMEOUT_EN
              || (cnt == HOLD_LAST)
`endif
             ) begin
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            ptr     <= idx_q + 3'd1;
            state   <= IDLE;
          end
`ifdef RR_ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed scoreboard bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic clk;
  logic rst_n;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [2:0] idx;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [2:0] idx);
    logic [7:0] exp_gnt;
    exp_gnt = v ? (8'b1 << idx) : 8'h00;
    check({tag, ".gnt"}, bus.gnt, exp_gnt);
    check({tag, ".idx"}, {5'd0, bus.gnt_idx}, {5'd0, (v ? idx : 3'd0)});
    check({tag, ".valid"}, {7'd0, bus.gnt_valid}, {7'd0, v});
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic cyc(input logic e, input logic [7:0] r, input logic v, input logic [2:0] idx,
                     input string tag);
    exp_t x;
    bus.en  = e;
    bus.req = r;
    x.valid = v;
    x.idx   = idx;
    x.tag   = tag;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      x = sbq.pop_front();
      check_outputs(x.tag, x.valid, x.idx);
    end
  endtask

  task automatic do_reset();
    bus.en  = 1'b0;
    bus.req = 8'h00;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.req = 8'h00;
    rst_n   = 1'b0;
    #3;
    check_outputs("reset", 1'b0, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester grant and release
    cyc(1'b1, 8'h01, 1'b1, 3'd0, "single_grant");
    cyc(1'b1, 8'h00, 1'b0, 3'd0, "single_release");

    // Full rotation with all requesting, wrap 7 -> 0
    do_reset();
    for (int o = 0; o < 8; o++) begin
      cyc(1'b1, 8'hFF, 1'b1, 3'(o), "rot_grant");
      cyc(1'b1, 8'hFF, 1'b1, 3'(o), "rot_hold");
      cyc(1'b1, 8'hFF & ~(8'b1 << o), 1'b0, 3'd0, "rot_release");
    end
    cyc(1'b1, 8'hFF, 1'b1, 3'd0, "rot_wrap");
    cyc(1'b1, 8'hFE, 1'b0, 3'd0, "rot_wrap_release");

    // Enable gating
    do_reset();
    cyc(1'b0, 8'h24, 1'b0, 3'd0, "en_low_a");
    cyc(1'b0, 8'h24, 1'b0, 3'd0, "en_low_b");
    cyc(1'b1, 8'h24, 1'b1, 3'd2, "en_raise");
    cyc(1'b0, 8'h24, 1'b1, 3'd2, "en_drop_hold");
    cyc(1'b0, 8'h20, 1'b0, 3'd0, "en_low_release");
    cyc(1'b0, 8'h20, 1'b0, 3'd0, "en_low_pending");
    cyc(1'b1, 8'h20, 1'b1, 3'd5, "pending_served");
    cyc(1'b1, 8'h00, 1'b0, 3'd0, "pending_release");

    // ptr wrap past 7 before reaching 6
    cyc(1'b1, 8'h40, 1'b1, 3'd6, "own6_grant");
    cyc(1'b1, 8'h00, 1'b0, 3'd0, "own6_release");
    cyc(1'b1, 8'h41, 1'b1, 3'd0, "wrap_pick0");
    cyc(1'b1, 8'h40, 1'b0, 3'd0, "wrap_release0");
    cyc(1'b1, 8'h00, 1'b0, 3'd0, "idle_gap");

    // Asynchronous reset mid-tenure
    cyc(1'b1, 8'h10, 1'b1, 3'd4, "pre_reset_grant");
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h10, 1'b1, 3'd4, "post_reset_grant");
    cyc(1'b1, 8'h00, 1'b0, 3'd0, "post_reset_release");

    // Long hold with a competitor waiting
    do_reset();
    cyc(1'b1, 8'h28, 1'b1, 3'd3, "long_grant");
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h28, 1'b1, 3'd3, "tmo_hold");
    cyc(1'b1, 8'h28, 1'b0, 3'd0, "tmo_revoke");
    cyc(1'b1, 8'h28, 1'b1, 3'd5, "tmo_next");
`else
    for (int i = 0; i < 110; i++) cyc(1'b1, 8'h28, 1'b1, 3'd3, "long_hold");
    cyc(1'b1, 8'h20, 1'b0, 3'd0, "long_release");
    cyc(1'b1, 8'h20, 1'b1, 3'd5, "long_next");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
